render_sequencer: RTL and testbench

Frame-level controller for the Tetris VGA renderer. Once per frame tick it sequences the pixel-drawing engines in a fixed order: full-screen clear (optional), board grid, then active piece. It also owns the select for the single shared VGA pixel-write port. It sits between game logic (redraw/clear requests) and the drawing engines, which expose start/done handshakes, and it ensures exactly one engine drives oX/oY/oColour/oPlot at a time.

---
 rtl/render_pkg.sv | 31 +++
 rtl/frame_tick_gen.sv | 27 ++
 rtl/render_sequencer.sv | 165 ++++++++++++++++
 tb/tb_render_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/render_pkg.sv
// Shared types and constants for the VGA renderer: sequencer states, pixel-port
// owner codes and screen geometry.
package render_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CLEAR = 2'b01,
    BOARD = 2'b10,
    PIECE = 2'b11
  } state_t;

  localparam logic [1:0] SEL_NONE  = 2'b00;
  localparam logic [1:0] SEL_CLEAR = 2'b01;
  localparam logic [1:0] SEL_BOARD = 2'b10;
  localparam logic [1:0] SEL_PIECE = 2'b11;

  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;
  localparam int BLOCK_SIZE = 6;
  localparam int BOARD_X0   = 50;

  function automatic logic [1:0] sel_of(input state_t s);
    case (s)
      CLEAR:   sel_of = SEL_CLEAR;
      BOARD:   sel_of = SEL_BOARD;
      PIECE:   sel_of = SEL_PIECE;
      default: sel_of = SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame counter; tick is high in the last cycle of each frame.
// No backpressure: the counter never stalls.
module frame_tick_gen #(
  parameter int FRAME_CYCLES = 833333
) (
  input  logic clock,
  input  logic resetn,
  output logic tick
);

  localparam logic [19:0] LAST = 20'(FRAME_CYCLES - 1);

  logic [19:0] count;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 20'd1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/render_sequencer.sv
// Per-frame sequencer for clear/board/piece engines and owner of the shared pixel port.
// One-cycle registered response to ticks and dones; stages abort after TIMEOUT_CYCLES.
module render_sequencer
  import render_pkg::*;
#(
  parameter int FRAME_CYCLES   = 833333,
  parameter int TIMEOUT_CYCLES = 32768
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       iRedraw,
  input  logic       iClearReq,
  input  logic       iClearDone,
  input  logic       iBoardDone,
  input  logic       iPieceDone,
  input  logic [7:0] iClearX,
  input  logic [6:0] iClearY,
  input  logic [2:0] iClearColour,
  input  logic       iClearPlot,
  input  logic [7:0] iBoardX,
  input  logic [6:0] iBoardY,
  input  logic [2:0] iBoardColour,
  input  logic       iBoardPlot,
  input  logic [7:0] iPieceX,
  input  logic [6:0] iPieceY,
  input  logic [2:0] iPieceColour,
  input  logic       iPiecePlot,
  output logic       oClearStart,
  output logic       oBoardStart,
  output logic       oPieceStart,
  output logic [1:0] oSel,
  output logic       oBusy,
  output logic       oFrameDone,
  output logic       oTimeout,
  output logic [7:0] oX,
  output logic [6:0] oY,
  output logic [2:0] oColour,
  output logic       oPlot
);

  localparam int SW = $clog2(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] STAGE_LAST = SW'(TIMEOUT_CYCLES - 1);

  state_t          state, state_nxt;
  logic [SW-1:0]   stage_cnt;
  logic            tick;
  logic            clear_pend, redraw_pend;
  logic            take_clear, take_redraw;
  logic            first_cycle, stage_expired;
  logic            frame_done_nxt, abort;

  frame_tick_gen #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_tick (
    .clock (clock),
    .resetn(resetn),
    .tick  (tick)
  );

  // The start cycle never accepts a done, so every stage lasts at least two cycles.
  assign first_cycle   = (stage_cnt == '0);
  assign stage_expired = (stage_cnt == STAGE_LAST);

  always_comb begin
    state_nxt      = state;
    take_clear     = 1'b0;
    take_redraw    = 1'b0;
    frame_done_nxt = 1'b0;
    abort          = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          if (clear_pend) begin
            state_nxt  = CLEAR;
            take_clear = 1'b1;
          end else if (redraw_pend) begin
            state_nxt   = BOARD;
            take_redraw = 1'b1;
          end
        end
      end
      CLEAR: begin
        if (iClearDone && !first_cycle) begin
          state_nxt = BOARD;
        end else if (stage_expired) begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end
      end
      BOARD: begin
        if (iBoardDone && !first_cycle) begin
          state_nxt = PIECE;
        end else if (stage_expired) begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end
      end
      PIECE: begin
        if (iPieceDone && !first_cycle) begin
          state_nxt      = IDLE;
          frame_done_nxt = 1'b1;
        end else if (stage_expired) begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= IDLE;
      stage_cnt   <= '0;
      clear_pend  <= 1'b0;
      redraw_pend <= 1'b0;
      oClearStart <= 1'b0;
      oBoardStart <= 1'b0;
      oPieceStart <= 1'b0;
      oSel        <= SEL_NONE;
      oBusy       <= 1'b0;
      oFrameDone  <= 1'b0;
      oTimeout    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state_nxt == IDLE) begin
        stage_cnt <= '0;
      end else begin
        stage_cnt <= stage_cnt + SW'(1);
      end
      // A request landing in the same cycle as its consumption stays pending.
      clear_pend  <= iClearReq | (clear_pend & ~take_clear);
      redraw_pend <= iRedraw | (redraw_pend & ~(take_clear | take_redraw));
      oClearStart <= (state_nxt == CLEAR) && (state != CLEAR);
      oBoardStart <= (state_nxt == BOARD) && (state != BOARD);
      oPieceStart <= (state_nxt == PIECE) && (state != PIECE);
      oSel        <= sel_of(state_nxt);
      oBusy       <= (state_nxt != IDLE);
      oFrameDone  <= frame_done_nxt;
      if (abort) begin
        oTimeout <= 1'b1;
      end
    end
  end

  always_comb begin
    oX      = '0;
    oY      = '0;
    oColour = '0;
    oPlot   = 1'b0;
    case (oSel)
      SEL_CLEAR: begin
        oX = iClearX;  oY = iClearY;  oColour = iClearColour;  oPlot = iClearPlot;
      end
      SEL_BOARD: begin
        oX = iBoardX;  oY = iBoardY;  oColour = iBoardColour;  oPlot = iBoardPlot;
      end
      SEL_PIECE: begin
        oX = iPieceX;  oY = iPieceY;  oColour = iPieceColour;  oPlot = iPiecePlot;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_render_sequencer.sv
// Bench for render_sequencer with FRAME_CYCLES=16 and TIMEOUT_CYCLES=8; ticks fall
// in cycles 15, 31, 47, ... counted from the first cycle after reset release.
module tb_render_sequencer;

  logic       clock = 1'b0;
  logic       resetn;
  logic       iRedraw, iClearReq, iClearDone, iBoardDone, iPieceDone;
  logic       oClearStart, oBoardStart, oPieceStart, oBusy, oFrameDone, oTimeout;
  logic [1:0] oSel;
  logic [7:0] oX;
  logic [6:0] oY;
  logic [2:0] oColour;
  logic       oPlot;

  always #5 clock = ~clock;

  render_sequencer #(
    .FRAME_CYCLES  (16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .iRedraw     (iRedraw),
    .iClearReq   (iClearReq),
    .iClearDone  (iClearDone),
    .iBoardDone  (iBoardDone),
    .iPieceDone  (iPieceDone),
    .iClearX     (8'd11),
    .iClearY     (7'd1),
    .iClearColour(3'd1),
    .iClearPlot  (1'b1),
    .iBoardX     (8'd22),
    .iBoardY     (7'd2),
    .iBoardColour(3'd2),
    .iBoardPlot  (1'b1),
    .iPieceX     (8'd33),
    .iPieceY     (7'd3),
    .iPieceColour(3'd3),
    .iPiecePlot  (1'b1),
    .oClearStart (oClearStart),
    .oBoardStart (oBoardStart),
    .oPieceStart (oPieceStart),
    .oSel        (oSel),
    .oBusy       (oBusy),
    .oFrameDone  (oFrameDone),
    .oTimeout    (oTimeout),
    .oX          (oX),
    .oY          (oY),
    .oColour     (oColour),
    .oPlot       (oPlot)
  );

  localparam int RST = 5, RDW = 4, CLR = 3, CDN = 2, BDN = 1, PDN = 0;
  localparam int EV_CS = 0, EV_BS = 1, EV_PS = 2, EV_FD = 3;
  localparam int LAST_CYC = 185;

  typedef struct {
    int         cyc;
    logic [5:0] ins;
    bit         chk;
    logic [1:0] sel;
    logic       busy;
    logic       to;
  } vec_t;

  typedef struct {
    int         cyc;
    int         kind;
    logic [1:0] sel;
  } ev_t;

  vec_t vecs[$];
  ev_t  evq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic stim(input int c, input int bitn);
    vec_t v;
    v.cyc = c; v.ins = '0; v.ins[bitn] = 1'b1;
    v.chk = 1'b0; v.sel = 2'b00; v.busy = 1'b0; v.to = 1'b0;
    vecs.push_back(v);
  endtask

  task automatic probe(input int c, input logic [1:0] s, input logic b, input logic t);
    vec_t v;
    v.cyc = c; v.ins = '0; v.chk = 1'b1; v.sel = s; v.busy = b; v.to = t;
    vecs.push_back(v);
  endtask

  task automatic expect_ev(input int c, input int k, input logic [1:0] s);
    ev_t e;
    e.cyc = c; e.kind = k; e.sel = s;
    evq.push_back(e);
  endtask

  task automatic check(input string name, input int c, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", name, c, act, req);
    end
  endtask

  function automatic int mux_x(input logic [1:0] s);
    case (s)
      2'b01:   mux_x = 11;
      2'b10:   mux_x = 22;
      2'b11:   mux_x = 33;
      default: mux_x = 0;
    endcase
  endfunction

  logic [5:0] ins;
  logic [3:0] pulses;
  ev_t        e;

  initial begin
    // Redraw only; each stage lasts 4 cycles (done in the stage's 4th cycle).
    probe(0, 2'b00, 1'b0, 1'b0);
    stim(3, RDW);
    probe(15, 2'b00, 1'b0, 1'b0);
    expect_ev(16, EV_BS, 2'b10);
    probe(17, 2'b10, 1'b1, 1'b0);
    stim(19, BDN);
    expect_ev(20, EV_PS, 2'b11);
    probe(22, 2'b11, 1'b1, 1'b0);
    stim(23, PDN);
    expect_ev(24, EV_FD, 2'b00);
    probe(24, 2'b00, 1'b0, 1'b0);

    // Clear and redraw requested together; the tick after completion stays idle.
    stim(35, CLR); stim(35, RDW);
    expect_ev(48, EV_CS, 2'b01);
    probe(50, 2'b01, 1'b1, 1'b0);
    stim(51, CDN);
    expect_ev(52, EV_BS, 2'b10);
    stim(55, BDN);
    expect_ev(56, EV_PS, 2'b11);
    stim(59, PDN);
    expect_ev(60, EV_FD, 2'b00);
    probe(64, 2'b00, 1'b0, 1'b0);

    // Stray dones, redraw during BOARD, second sequence on the next tick.
    stim(67, RDW);
    stim(70, CDN); stim(72, BDN);
    expect_ev(80, EV_BS, 2'b10);
    stim(80, BDN);
    stim(81, RDW);
    probe(81, 2'b10, 1'b1, 1'b0);
    stim(82, PDN);
    stim(83, BDN);
    probe(83, 2'b10, 1'b1, 1'b0);
    expect_ev(84, EV_PS, 2'b11);
    stim(87, PDN);
    expect_ev(88, EV_FD, 2'b00);
    probe(89, 2'b00, 1'b0, 1'b0);
    expect_ev(96, EV_BS, 2'b10);
    stim(99, BDN);
    expect_ev(100, EV_PS, 2'b11);
    stim(103, PDN);
    expect_ev(104, EV_FD, 2'b00);

    // Board done withheld: abort 8 cycles after the start, sticky timeout.
    stim(107, RDW);
    expect_ev(112, EV_BS, 2'b10);
    probe(119, 2'b10, 1'b1, 1'b0);
    probe(120, 2'b00, 1'b0, 1'b1);
    probe(135, 2'b00, 1'b0, 1'b1);

    // Reset during PIECE, then a sequence on the restarted frame counter.
    stim(131, RDW);
    expect_ev(144, EV_BS, 2'b10);
    stim(147, BDN);
    expect_ev(148, EV_PS, 2'b11);
    probe(149, 2'b11, 1'b1, 1'b1);
    stim(150, RST);
    probe(151, 2'b00, 1'b0, 1'b0);
    stim(152, PDN);
    stim(153, RDW);
    expect_ev(167, EV_BS, 2'b10);
    stim(170, BDN);
    expect_ev(171, EV_PS, 2'b11);
    stim(174, PDN);
    expect_ev(175, EV_FD, 2'b00);
    probe(176, 2'b00, 1'b0, 1'b0);

    resetn = 1'b0;
    iRedraw = 1'b0; iClearReq = 1'b0;
    iClearDone = 1'b0; iBoardDone = 1'b0; iPieceDone = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    for (int c = 0; c <= LAST_CYC; c++) begin
      ins = '0;
      foreach (vecs[i]) if (vecs[i].cyc == c) ins = ins | vecs[i].ins;
      resetn     = ~ins[RST];
      iRedraw    = ins[RDW];
      iClearReq  = ins[CLR];
      iClearDone = ins[CDN];
      iBoardDone = ins[BDN];
      iPieceDone = ins[PDN];

      @(negedge clock);
      while (evq.size() > 0 && evq[0].cyc < c) begin
        e = evq.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_event kind=%0d got=absent want=cycle %0d", e.kind, e.cyc);
      end
      pulses = {oFrameDone, oPieceStart, oBoardStart, oClearStart};
      for (int k = 0; k < 4; k++) begin
        if (pulses[k]) begin
          if (evq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event cycle=%0d got=kind %0d want=none", c, k);
          end else begin
            e = evq.pop_front();
            check("event_cycle", c, c, e.cyc);
            check("event_kind", c, k, e.kind);
            check("event_sel", c, int'(oSel), int'(e.sel));
          end
        end
      end
      foreach (vecs[i]) begin
        if (vecs[i].chk && vecs[i].cyc == c) begin
          check("sel", c, int'(oSel), int'(vecs[i].sel));
          check("busy", c, int'(oBusy), int'(vecs[i].busy));
          check("timeout", c, int'(oTimeout), int'(vecs[i].to));
          check("pixel_x", c, int'(oX), mux_x(vecs[i].sel));
          check("pixel_plot", c, int'(oPlot), int'(vecs[i].sel != 2'b00));
        end
      end
      @(posedge clock);
      #1;
    end

    check("events_left", LAST_CYC, evq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
